// File: rtl/vga_pkg.sv
// Shared types and default timing constants for the VGA receive path.
// Counter width and the saturating increment used by every line/pixel counter live here too.
package vga_pkg;

  typedef enum logic [1:0] {
    ST_SEARCH,
    ST_ALIGN,
    ST_LOCK
  } vga_state_t;

  localparam int unsigned H_TOTAL_DEF = 800;
  localparam int unsigned V_TOTAL_DEF = 525;
  localparam int unsigned H_SYNC_DEF  = 96;
  localparam int unsigned V_SYNC_DEF  = 2;
  localparam int unsigned H_ACTIVE    = 640;
  localparam int unsigned V_ACTIVE    = 480;

  localparam int unsigned CNT_W = 10;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

endpackage

// File: rtl/vga_edge_sync.sv
// Two-flop synchroniser followed by an edge detector that compares consecutive
// strobe-qualified samples of the synchronised level.
module vga_edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1, s2, prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      prev <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (en) prev <= s2;
    end
  end

  assign level = s2;
  assign rise  = en & s2 & ~prev;
  assign fall  = en & ~s2 & prev;

endmodule

// File: rtl/vga_rx_decoder.sv
// VGA timing receiver: measures sync timing against the parameters, tracks lock
// through SEARCH/ALIGN/LOCK, and captures active pixels with their coordinates.
module vga_rx_decoder
  import vga_pkg::*;
#(
  parameter int unsigned H_TOTAL = H_TOTAL_DEF,
  parameter int unsigned V_TOTAL = V_TOTAL_DEF,
  parameter int unsigned H_SYNC  = H_SYNC_DEF,
  parameter int unsigned V_SYNC  = V_SYNC_DEF
) (
  input  logic        clk_50m,
  input  logic        btn_rst,
  input  logic        pix_en,
  input  logic        vga_hsync,
  input  logic        vga_vsync,
  input  logic        bright,
  input  logic [7:0]  vga_r,
  input  logic [7:0]  vga_g,
  input  logic [7:0]  vga_b,
  output logic        pix_valid,
  output logic [9:0]  pix_x,
  output logic [9:0]  pix_y,
  output logic [23:0] pix_rgb,
  output logic        frame_start,
  output logic        locked,
  output logic        timing_err,
  output logic [9:0]  line_len
);

  localparam logic [CNT_W-1:0] HT  = CNT_W'(H_TOTAL);
  localparam logic [CNT_W-1:0] VT1 = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] HSW = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] VSW = CNT_W'(V_SYNC);

  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic br_lvl, br_rise, br_fall;
  logic [23:0] rgb_s1, rgb_s2;

  logic [CNT_W-1:0] hcnt, vcnt, hs_low, vs_lines, ax, ay;
  logic [CNT_W-1:0] hcnt_inc;
  logic             viol, err_now;
  vga_state_t       state, state_nxt;

  vga_edge_sync u_hs (
    .clk(clk_50m), .rst(btn_rst), .en(pix_en), .din(vga_hsync),
    .level(hs_lvl), .rise(hs_rise), .fall(hs_fall)
  );

  vga_edge_sync u_vs (
    .clk(clk_50m), .rst(btn_rst), .en(pix_en), .din(vga_vsync),
    .level(vs_lvl), .rise(vs_rise), .fall(vs_fall)
  );

  vga_edge_sync u_br (
    .clk(clk_50m), .rst(btn_rst), .en(pix_en), .din(bright),
    .level(br_lvl), .rise(br_rise), .fall(br_fall)
  );

  // Colour shares the same two-stage delay as bright so a pixel stays aligned with its qualifier.
  always_ff @(posedge clk_50m) begin
    if (btn_rst) begin
      rgb_s1 <= '0;
      rgb_s2 <= '0;
    end else begin
      rgb_s1 <= {vga_r, vga_g, vga_b};
      rgb_s2 <= rgb_s1;
    end
  end

  assign hcnt_inc = sat_inc(hcnt);

  // Sync widths are counted from the falling edge (which itself is a low sample) and judged at the rise.
  always_ff @(posedge clk_50m) begin
    if (btn_rst) begin
      hcnt     <= '0;
      vcnt     <= '0;
      line_len <= '0;
      hs_low   <= '0;
      vs_lines <= '0;
    end else if (pix_en) begin
      hcnt <= hs_fall ? '0 : hcnt_inc;
      if (vs_fall)      vcnt <= '0;
      else if (hs_fall) vcnt <= sat_inc(vcnt);
      if (hs_fall) line_len <= hcnt_inc;
      if (hs_fall)      hs_low <= CNT_W'(1);
      else if (!hs_lvl) hs_low <= sat_inc(hs_low);
      if (vs_fall)                 vs_lines <= CNT_W'(1);
      else if (hs_fall && !vs_lvl) vs_lines <= sat_inc(vs_lines);
    end
  end

  assign viol = (hs_rise && (hs_low != HSW))
             || (vs_rise && (vs_lines != VSW))
             || (hs_fall && (hcnt_inc != HT))
             || (vs_fall && (vcnt != VT1));

  always_ff @(posedge clk_50m) begin
    if (btn_rst) state <= ST_SEARCH;
    else if (pix_en) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_SEARCH: if (vs_fall) state_nxt = ST_ALIGN;
      ST_ALIGN: begin
        if (viol)         state_nxt = ST_SEARCH;
        else if (vs_fall) state_nxt = ST_LOCK;
      end
      ST_LOCK:   if (viol) state_nxt = ST_SEARCH;
      default:   state_nxt = ST_SEARCH;
    endcase
  end

  always_comb begin
    locked  = (state == ST_LOCK);
    err_now = viol && (state != ST_SEARCH);
  end

  always_ff @(posedge clk_50m) begin
    if (btn_rst) begin
      pix_valid   <= 1'b0;
      frame_start <= 1'b0;
      timing_err  <= 1'b0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_rgb     <= '0;
      ax          <= '0;
      ay          <= '0;
    end else begin
      pix_valid   <= pix_en & br_lvl;
      frame_start <= vs_fall;
      timing_err  <= err_now;
      if (pix_en && br_lvl) begin
        pix_x   <= br_rise ? '0 : ax;
        pix_y   <= ay;
        pix_rgb <= rgb_s2;
        ax      <= br_rise ? CNT_W'(1) : sat_inc(ax);
      end
      if (vs_fall)      ay <= '0;
      else if (br_fall) ay <= sat_inc(ay);
    end
  end

endmodule

// File: tb/tb_vga_rx_decoder.sv
// Scoreboard bench for vga_rx_decoder on a scaled-down raster (48x12 total, 32x8 active).
// Stimulus pushes expected pixels; a negedge monitor pops and compares on every pix_valid.
module tb_vga_rx_decoder;

  localparam int HT  = 48;
  localparam int VT  = 12;
  localparam int HSW = 4;
  localparam int VSW = 2;
  localparam int HA0 = 8;
  localparam int AW  = 32;
  localparam int VA0 = 3;
  localparam int AH  = 8;

  localparam int F_SHORT = 3;
  localparam int F_HSW   = 4;
  localparam int F_RST   = 6;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [23:0] rgb;
  } pix_t;

  logic        clk_50m = 1'b0;
  logic        btn_rst;
  logic        pix_en;
  logic        vga_hsync, vga_vsync, bright;
  logic [7:0]  vga_r, vga_g, vga_b;
  logic        pix_valid;
  logic [9:0]  pix_x, pix_y;
  logic [23:0] pix_rgb;
  logic        frame_start, locked, timing_err;
  logic [9:0]  line_len;

  int   tests = 0, fails = 0;
  int   npix = 0, err_cnt = 0, fs_cnt = 0, stall_pv = 0, corner_seen = 0;
  logic stall_win = 1'b0;
  logic blank = 1'b0;
  pix_t sbq[$];

  vga_rx_decoder #(.H_TOTAL(HT), .V_TOTAL(VT), .H_SYNC(HSW), .V_SYNC(VSW)) dut (
    .clk_50m(clk_50m), .btn_rst(btn_rst), .pix_en(pix_en),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync), .bright(bright),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y), .pix_rgb(pix_rgb),
    .frame_start(frame_start), .locked(locked), .timing_err(timing_err),
    .line_len(line_len)
  );

  always #10 clk_50m = ~clk_50m;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  function automatic logic [23:0] pat(input int x, input int y);
    logic [7:0] a, b, c;
    a = 8'(x * 3 + 1);
    b = 8'(y * 17 + 5);
    c = 8'(x ^ y);
    return (x == AW - 1 && y == AH - 1) ? 24'hFF00AA : {a, b, c};
  endfunction

  // Monitor: pops expected pixels and tallies pulse outputs.
  always @(negedge clk_50m) begin
    if (pix_valid) begin
      pix_t e;
      npix++;
      if (stall_win) stall_pv++;
      tests++;
      if (sbq.size() == 0) begin
        fails++;
        $display("FAIL pix_unexpected: got pix_valid x=%0d y=%0d, required none", pix_x, pix_y);
      end else begin
        e = sbq.pop_front();
        if ({pix_x, pix_y, pix_rgb} !== e) begin
          fails++;
          $display("FAIL pix: got x=%0d y=%0d rgb=%06h required x=%0d y=%0d rgb=%06h",
                   pix_x, pix_y, pix_rgb, e.x, e.y, e.rgb);
        end
        if (e.x == 10'(AW - 1) && e.y == 10'(AH - 1)) corner_seen++;
      end
    end
    if (timing_err) err_cnt++;
    if (frame_start) fs_cnt++;
  end

  task automatic drive(input logic hs, input logic vs, input logic br, input logic [23:0] rgb);
    @(negedge clk_50m);
    vga_hsync = hs;
    vga_vsync = vs;
    bright    = br;
    {vga_r, vga_g, vga_b} = rgb;
    pix_en    = 1'b1;
    @(negedge clk_50m);
    pix_en    = 1'b0;
  endtask

  task automatic hook(input int f, input int l, input int c);
    if (f == 0 && l == 5 && c == 0) check("align_not_locked", 32'(locked), 32'd0);
    if (f == 2 && l == 0 && c == 4) begin
      check("lock_frame3", 32'(locked), 32'd1);
      check("no_err_ideal", err_cnt, 0);
      check("pix_count_2frames", npix, 2 * AW * AH);
      check("frame_start_cnt", fs_cnt, 3);
      check("line_len_ideal", 32'(line_len), HT);
    end
    if (f == 2 && l == 6 && c == 20) begin
      repeat (2) @(negedge clk_50m);
      stall_win = 1'b1;
      repeat (98) @(negedge clk_50m);
      stall_win = 1'b0;
      check("stall_no_pix_valid", stall_pv, 0);
      check("stall_locked", 32'(locked), 32'd1);
    end
    if (f == 2 && l == 7 && c == 4) begin
      check("len_after_stall", 32'(line_len), HT);
      check("no_err_after_stall", err_cnt, 0);
    end
    if (f == F_SHORT && l == 4 && c == 4) begin
      check("short_err_pulse", err_cnt, 1);
      check("short_unlocked", 32'(locked), 32'd0);
      check("short_line_len", 32'(line_len), HT - 1);
    end
    if (f == F_HSW && l == 5 && c == 8) begin
      check("hsw_err_pulse", err_cnt, 2);
      check("hsw_unlocked", 32'(locked), 32'd0);
    end
    if (f == 5 && l == 2 && c == 0) begin
      check("no_lock_after_hsw", 32'(locked), 32'd0);
      check("err_cnt_f5", err_cnt, 2);
    end
    if (f == F_RST && l == 2 && c == 0) check("relock", 32'(locked), 32'd1);
    if (f == F_RST && l == 6 && c == 44) begin
      btn_rst = 1'b1;
      @(negedge clk_50m);
      btn_rst = 1'b0;
      check("rst_locked", 32'(locked), 32'd0);
      check("rst_pix_x", 32'(pix_x), 32'd0);
      check("rst_pix_y", 32'(pix_y), 32'd0);
      check("rst_pix_rgb", 32'(pix_rgb), 32'd0);
      check("rst_line_len", 32'(line_len), 32'd0);
      check("rst_pulses", {29'd0, pix_valid, frame_start, timing_err}, 32'd0);
      blank = 1'b1;
    end
    if (f == 7 && l == 2 && c == 0) begin
      check("align_after_rst", 32'(locked), 32'd0);
      check("no_err_in_search", err_cnt, 2);
    end
    if (f == 8 && l == 2 && c == 0) check("relock_after_rst", 32'(locked), 32'd1);
  endtask

  task automatic frame(input int f);
    int   len, hsw;
    logic hs, vs, br;
    logic [23:0] rgb;
    pix_t e;
    blank = 1'b0;
    for (int l = 0; l < VT; l++) begin
      len = (f == F_SHORT && l == 3) ? HT - 1 : HT;
      hsw = (f == F_HSW && l == 5) ? HSW - 1 : HSW;
      for (int c = 0; c < len; c++) begin
        hook(f, l, c);
        hs  = (c >= hsw);
        vs  = (l >= VSW);
        br  = !blank && c >= HA0 && c < HA0 + AW && l >= VA0 && l < VA0 + AH;
        rgb = br ? pat(c - HA0, l - VA0) : 24'h0;
        if (br) begin
          e.x   = 10'(c - HA0);
          e.y   = 10'(l - VA0);
          e.rgb = rgb;
          sbq.push_back(e);
        end
        drive(hs, vs, br, rgb);
      end
    end
  endtask

  initial begin
    btn_rst = 1'b1;
    pix_en  = 1'b0;
    vga_hsync = 1'b1;
    vga_vsync = 1'b1;
    bright  = 1'b0;
    {vga_r, vga_g, vga_b} = 24'h0;
    repeat (3) @(negedge clk_50m);
    check("reset_locked", 32'(locked), 32'd0);
    check("reset_line_len", 32'(line_len), 32'd0);
    check("reset_pix", {pix_x, pix_y, 12'd0}, 32'd0);
    check("reset_pulses", {29'd0, pix_valid, frame_start, timing_err}, 32'd0);
    btn_rst = 1'b0;
    repeat (5) drive(1'b1, 1'b1, 1'b0, 24'h0);
    for (int f = 0; f < 9; f++) frame(f);
    repeat (4) drive(1'b1, 1'b1, 1'b0, 24'h0);
    check("sb_drained", sbq.size(), 0);
    check("corner_pixels", corner_seen, 8);
    check("err_cnt_final", err_cnt, 2);
    check("frame_start_final", fs_cnt, 9);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
